// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: idle transmit byte, peripheral register map, FSM states.
package spi_target_pkg;

    localparam logic [7:0] TX_IDLE_BYTE_DEFAULT = 8'hFF;

    // Byte offsets of the CPU-visible registers on the peripheral bus.
    localparam logic [3:0] REG_RX_DATA = 4'h0;
    localparam logic [3:0] REG_TX_DATA = 4'h4;
    localparam logic [3:0] REG_STATUS  = 4'h8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/spi_target_if.sv
// CPU-side holding-register interface of the SPI target.
interface spi_target_if;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_valid;
    logic       rx_read;
    logic       overrun;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_empty;
    logic       selected;

    modport master (
        output rx_read, tx_data, tx_write,
        input  rx_data, rx_dc, rx_valid, overrun, tx_empty, selected
    );

    modport slave (
        input  rx_read, tx_data, tx_write,
        output rx_data, rx_dc, rx_valid, overrun, tx_empty, selected
    );
endinterface

// File: rtl/spi_target_sync_2ff.sv
// Two-flop synchronizer for one asynchronous pin, with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= {2{RST_VAL}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with oversampled pins, one-byte RX/TX holding registers and a D/C sideband.
import spi_target_pkg::*;

module spi_target #(
    parameter logic [7:0] TX_IDLE_BYTE = TX_IDLE_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck_i,
    input  logic        spi_cs_i,
    input  logic        spi_mosi_i,
    input  logic        spi_dc_i,
    output logic        spi_miso_o,
    spi_target_if.slave bus
);
    logic       sck_s, cs_s, mosi_s, dc_s;
    logic       sck_q, cs_q;
    logic [1:0] settle_q;
    logic       armed_q;

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q, tx_shift_q, tx_hold_q, rx_data_q;
    logic       rx_dc_q, rx_valid_q, overrun_q, tx_empty_q;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .d_i(spi_sck_i),  .q_o(sck_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d_i(spi_cs_i),   .q_o(cs_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(spi_mosi_i), .q_o(mosi_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_dc   (.clk(clk), .rst(rst), .d_i(spi_dc_i),   .q_o(dc_s));

    logic       sck_rise, sck_fall, cs_fall, cs_rise;
    logic       start_d, load_d, complete_d;
    logic [7:0] rx_byte_d, tx_next_d;

    assign sck_rise   = sck_s & ~sck_q;
    assign sck_fall   = ~sck_s & sck_q;
    assign cs_fall    = ~cs_s & cs_q;
    assign cs_rise    = cs_s & ~cs_q;

    assign start_d    = (state_q == ST_IDLE) && armed_q && cs_fall;
    assign load_d     = start_d ||
                        ((state_q == ST_ACTIVE) && !cs_rise && sck_fall && (bit_cnt_q == 3'd0));
    assign complete_d = (state_q == ST_ACTIVE) && !cs_rise && sck_rise && (bit_cnt_q == 3'd7);
    assign rx_byte_d  = {rx_shift_q[6:0], mosi_s};
    assign tx_next_d  = tx_empty_q ? TX_IDLE_BYTE : tx_hold_q;

    // The CS synchronizer resets high, so a select already low at reset release would look
    // like a fresh falling edge; only arm once a genuinely synchronized high level is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            sck_q    <= sck_s;
            cs_q     <= cs_s;
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            tx_hold_q  <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_dc_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            tx_empty_q <= 1'b1;
        end else begin
            if (bus.rx_read) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (load_d) begin
                tx_shift_q <= tx_next_d;
                tx_empty_q <= 1'b1;
            end
            // A write colliding with a load keeps the new byte pending for the next load.
            if (bus.tx_write) begin
                tx_hold_q  <= bus.tx_data;
                tx_empty_q <= 1'b0;
            end
            if (complete_d) begin
                if (!rx_valid_q || bus.rx_read) begin
                    rx_data_q  <= rx_byte_d;
                    rx_dc_q    <= dc_s;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q  <= 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        state_q   <= ST_ACTIVE;
                        bit_cnt_q <= 3'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state_q    <= ST_IDLE;
                        bit_cnt_q  <= 3'd0;
                        rx_shift_q <= 8'h00;
                    end else if (sck_rise) begin
                        rx_shift_q <= rx_byte_d;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                    end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spi_miso_o   = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b1;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_dc    = rx_dc_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.tx_empty = tx_empty_q;
    assign bus.selected = (state_q == ST_ACTIVE);
endmodule

// File: doc/spi_target.md
# spi_target

SPI target (peripheral-side) block that answers an SPI controller using the same wire protocol as the core's `spi_ctrl`: mode 0, MSB first, active-low select, plus a D/C sideband sampled with each byte. It sits between external pins (ui_in/uo_out style IOs) and the core's peripheral bus. It gives the CPU a one-byte receive holding register and a one-byte transmit holding register. All pin inputs are asynchronous to `clk` and are oversampled.

## Interface
- `TX_IDLE_BYTE`, default 8'hFF: byte shifted out when no transmit data is pending.
- `clk` input 1: system clock; all state on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `spi_sck` input 1: controller clock, asynchronous.
- `spi_cs` input 1: select, active low, asynchronous.
- `spi_mosi` input 1: controller data out, asynchronous.
- `spi_dc` input 1: data/command sideband, asynchronous.
- `spi_miso` output 1: target data out.
- `rx_data` output 8: last received byte.
- `rx_dc` output 1: D/C value captured with `rx_data`.
- `rx_valid` output 1: `rx_data` holds an unread byte.
- `rx_read` input 1: one-cycle pulse that consumes `rx_data`.
- `overrun` output 1: sticky; a byte was dropped because `rx_valid` was already set.
- `tx_data` input 8: byte to send.
- `tx_write` input 1: one-cycle pulse that writes `tx_data` into the TX holding register.
- `tx_empty` output 1: TX holding register is free.
- `selected` output 1: synchronized select is active.

## Operation
- **Synchronizers.** `spi_sck`, `spi_cs`, `spi_mosi` and `spi_dc` each pass through a 2-flop synchronizer. Reset values are sck=0, cs=1, mosi=0, dc=0.
  - Edge detection compares the synchronized SCK and CS against one further registered copy.
- **States.** IDLE and ACTIVE.
  - IDLE → ACTIVE on a synchronized CS falling edge. On that edge: bit counter := 0. TX shift register := TX holding register if `tx_empty`=0, and `tx_empty` := 1; otherwise TX shift register := `TX_IDLE_BYTE`.
  - ACTIVE → IDLE on a synchronized CS rising edge. The bit counter is cleared and partial RX bits are discarded. A TX byte already loaded into the shift register is consumed, not restored.
- **SCK rising edge in ACTIVE.**
  - rx_shift := {rx_shift[6:0], mosi_sync}, and the counter increments mod 8.
  - When the counter wraps 7→0 (8th bit), the byte completes:
    - If `rx_valid`=0, or `rx_read` is asserted in the same cycle: `rx_data` := the completed byte, `rx_dc` := dc_sync, `rx_valid` := 1.
    - Otherwise the new byte is dropped, `rx_data` is unchanged, and `overrun` := 1.
- **SCK falling edge in ACTIVE.**
  - If counter ≠ 0: shift the TX shift register left by one.
  - If counter = 0 (a byte has just completed): load the next byte with the same rule as at select.
- **`spi_miso`.** Equals TX shift register bit 7 while ACTIVE; 1 while IDLE.
- **`rx_read`.** Clears `rx_valid` and `overrun`, except in the simultaneous-completion case above, where `rx_valid` stays 1 and `overrun` is cleared.
- **`tx_write`.** Writes the TX holding register and sets `tx_empty` := 0, overwriting any unsent value.
  - If `tx_write` and a load occur in the same cycle, the load takes the old register contents. The new value remains in the register and `tx_empty` = 0.
- **SCK edges in IDLE** are ignored.
- **Reset** while CS is low: the block stays IDLE until a CS high followed by a CS low is seen.

## Timing
- Reset values:
  - `spi_miso`=1, `rx_data`=0, `rx_dc`=0, `rx_valid`=0, `overrun`=0, `tx_empty`=1, `selected`=0.
  - Internal shift registers and the counter are 0.
- Pin-to-edge-detect latency is 3 clk cycles (2 synchronizer flops + 1 edge register).
- `rx_valid` rises 1 cycle after the detected 8th SCK rising edge.
- `spi_miso` updates 4 clk cycles after an SCK falling pin edge. Controller constraints:
  - SCK high time and low time ≥ 4 clk cycles each, plus controller setup time.
  - CS low to first SCK rise ≥ 4 clk cycles.
- All outputs are registered except `spi_miso`, which is a mux of registered signals.
- `rx_read` and `tx_write` have single-cycle effect. Holding them high repeats the action each cycle.

## Structure
- Shared constants package/header holds `TX_IDLE_BYTE` default and the peripheral register offsets for the RX data, TX data and status registers.
- Sub-module: `sync_2ff` (2-flop synchronizer with parameterised reset value), instantiated once per pin input.

## Test plan
- tx_write 0xA5; controller sends 0x3C with dc=1 → rx_data=0x3C, rx_dc=1, rx_valid=1; controller reads 0xA5; tx_empty=1 after the CS fall.
- No tx_write; controller sends 0x00 → controller reads 0xFF; rx_valid=1.
- Two bytes 0x11, 0x22 in one select with no rx_read → rx_data=0x11, overrun=1; an rx_read pulse then clears rx_valid and overrun.
- rx_read pulsed in the same cycle as completion of byte 0x77 → rx_data=0x77, rx_valid=1, overrun=0.
- CS deasserted after 5 bits, then a full byte 0xC3 → rx_valid set exactly once, rx_data=0xC3.
- rst asserted mid-byte with CS held low, then more SCK pulses → no rx_valid; after CS high→low, a byte 0x5A is received correctly.
